// File: rtl/jtag_tap_csr.sv
// -----------------------------------------------------------------------------
// jtag_tap_csr
//
// Single-clock IEEE 1149.1 TAP controller with an integrated CSR access port.
// The TAP state machine, instruction register, data registers and TDO mux are
// all clocked by tck. Three CSR instructions let a debugger set an address,
// issue read/write requests, and run auto-incrementing bursts. A CSR update that
// arrives while a request is still outstanding is dropped and latches a sticky
// overrun flag.
//
// Ports
//   tck        in   sole clock, rising edge
//   trst       in   synchronous active-high reset
//   tms, tdi   in   JTAG mode select / serial data in
//   tdo        out  serial data out (0 when not shifting)
//   tdo_oe     out  high in SHIR / SHDR
//   csr_req    out  request, held until csr_ack
//   csr_we     out  1 = write, 0 = read
//   csr_addr   out  CSR address [ADDR_W]
//   csr_wdata  out  CSR write data [DATA_W]
//   csr_ack    in   CSR acknowledge
//   csr_rdata  in   CSR read data [DATA_W], sampled on completion
//   dbg_fsm    out  current TAP state encoding
// -----------------------------------------------------------------------------
module jtag_tap_csr #(
    parameter int unsigned IR_LEN     = 4,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DATA_W     = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_oe,
    output logic              csr_req,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic              csr_ack,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic [3:0]        dbg_fsm
);

    typedef enum logic [3:0] {
        TLR   = 4'd0,
        RTI   = 4'd1,
        SELDR = 4'd2,
        CAPDR = 4'd3,
        SHDR  = 4'd4,
        EX1DR = 4'd5,
        PSDR  = 4'd6,
        EX2DR = 4'd7,
        UPDR  = 4'd8,
        SELIR = 4'd9,
        CAPIR = 4'd10,
        SHIR  = 4'd11,
        EX1IR = 4'd12,
        PSIR  = 4'd13,
        EX2IR = 4'd14,
        UPIR  = 4'd15
    } tap_state_t;

    localparam logic [IR_LEN-1:0] INS_IDCODE = IR_LEN'(3'd1);
    localparam logic [IR_LEN-1:0] INS_ADDR   = IR_LEN'(3'd2);
    localparam logic [IR_LEN-1:0] INS_DATA   = IR_LEN'(3'd3);
    localparam logic [IR_LEN-1:0] INS_AUTO   = IR_LEN'(3'd4);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

    // TAP state
    tap_state_t state_r;
    tap_state_t state_next_s;

    // Instruction path
    logic [IR_LEN-1:0] ir_r;
    logic [IR_LEN-1:0] ir_sh_r;

    // Data register shift chains
    logic [31:0]       idcode_sh_r;
    logic [ADDR_W+1:0] addr_sh_r;
    logic [DATA_W:0]   data_sh_r;
    logic              bypass_sh_r;

    // Instruction decode
    logic sel_idcode_s;
    logic sel_addr_s;
    logic sel_data_s;
    logic sel_auto_s;
    logic sel_bypass_s;

    // CSR side state
    logic [ADDR_W-1:0] addr_reg_r;
    logic [DATA_W-1:0] rdata_r;
    logic              overrun_r;
    logic              auto_r;
    logic              csr_req_r;
    logic              csr_we_r;
    logic [ADDR_W-1:0] csr_addr_r;
    logic [DATA_W-1:0] csr_wdata_r;

    // CSR control strobes
    logic              ack_done_s;
    logic              addr_update_s;
    logic              data_update_s;
    logic              issue_s;
    logic              overrun_set_s;
    logic [ADDR_W-1:0] addr_issue_s;

    // TDO path
    logic dr_tdo_s;
    logic tdo_s;
    logic tdo_oe_s;

    // TAP state register
    always_ff @(posedge tck) begin
        if (trst) begin
            state_r <= TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // TAP next-state decode, one transition per tms sample
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TLR:     state_next_s = tms ? TLR   : RTI;
            RTI:     state_next_s = tms ? SELDR : RTI;
            SELDR:   state_next_s = tms ? SELIR : CAPDR;
            CAPDR:   state_next_s = tms ? EX1DR : SHDR;
            SHDR:    state_next_s = tms ? EX1DR : SHDR;
            EX1DR:   state_next_s = tms ? UPDR  : PSDR;
            PSDR:    state_next_s = tms ? EX2DR : PSDR;
            EX2DR:   state_next_s = tms ? UPDR  : SHDR;
            UPDR:    state_next_s = tms ? SELDR : RTI;
            SELIR:   state_next_s = tms ? TLR   : CAPIR;
            CAPIR:   state_next_s = tms ? EX1IR : SHIR;
            SHIR:    state_next_s = tms ? EX1IR : SHIR;
            EX1IR:   state_next_s = tms ? UPIR  : PSIR;
            PSIR:    state_next_s = tms ? EX2IR : PSIR;
            EX2IR:   state_next_s = tms ? UPIR  : SHIR;
            UPIR:    state_next_s = tms ? SELDR : RTI;
            default: state_next_s = TLR;
        endcase
    end

    // Instruction shift register and current instruction
    always_ff @(posedge tck) begin
        if (trst) begin
            ir_r    <= INS_IDCODE;
            ir_sh_r <= IR_LEN'(1'b0);
        end else begin
            if (state_r == CAPIR) begin
                ir_sh_r <= IR_CAPTURE;
            end else if (state_r == SHIR) begin
                ir_sh_r <= {tdi, ir_sh_r[IR_LEN-1:1]};
            end
            // Forcing IDCODE on the way into TLR makes it current for the whole
            // time the TAP sits in TLR; CSR state is deliberately left alone.
            if (state_next_s == TLR) begin
                ir_r <= INS_IDCODE;
            end else if (state_r == UPIR) begin
                ir_r <= ir_sh_r;
            end
        end
    end

    // Instruction decode; unknown codes and all-ones select BYPASS
    always_comb begin
        sel_idcode_s = 1'b0;
        sel_addr_s   = 1'b0;
        sel_data_s   = 1'b0;
        sel_auto_s   = 1'b0;
        case (ir_r)
            INS_IDCODE: sel_idcode_s = 1'b1;
            INS_ADDR:   sel_addr_s   = 1'b1;
            INS_DATA:   sel_data_s   = 1'b1;
            INS_AUTO: begin
                sel_data_s = 1'b1;
                sel_auto_s = 1'b1;
            end
            default:    sel_idcode_s = 1'b0;
        endcase
        sel_bypass_s = ~(sel_idcode_s | sel_addr_s | sel_data_s);
    end

    // Data register capture and LSB-first shift; tdi enters at each chain's MSB
    always_ff @(posedge tck) begin
        if (trst) begin
            idcode_sh_r <= 32'd0;
            addr_sh_r   <= '0;
            data_sh_r   <= '0;
            bypass_sh_r <= 1'b0;
        end else if (state_r == CAPDR) begin
            if (sel_idcode_s) begin
                idcode_sh_r <= IDCODE_VAL;
            end
            if (sel_addr_s) begin
                addr_sh_r <= {overrun_r, csr_req_r, addr_reg_r};
            end
            if (sel_data_s) begin
                data_sh_r <= {csr_req_r, rdata_r};
            end
            if (sel_bypass_s) begin
                bypass_sh_r <= 1'b0;
            end
        end else if (state_r == SHDR) begin
            if (sel_idcode_s) begin
                idcode_sh_r <= {tdi, idcode_sh_r[31:1]};
            end
            if (sel_addr_s) begin
                addr_sh_r <= {tdi, addr_sh_r[ADDR_W+1:1]};
            end
            if (sel_data_s) begin
                data_sh_r <= {tdi, data_sh_r[DATA_W:1]};
            end
            if (sel_bypass_s) begin
                bypass_sh_r <= tdi;
            end
        end
    end

    // CSR control strobes
    always_comb begin
        ack_done_s    = csr_req_r & csr_ack;
        addr_update_s = (state_r == UPDR) & sel_addr_s;
        data_update_s = (state_r == UPDR) & sel_data_s;
        // A request completing on this same edge frees the port, so the
        // update is accepted rather than counted as an overrun.
        issue_s       = data_update_s & (~csr_req_r | ack_done_s);
        overrun_set_s = data_update_s & csr_req_r & ~csr_ack;
        // The new request must see the address after a completing burst step.
        if (ack_done_s && auto_r) begin
            addr_issue_s = addr_reg_r + ADDR_W'(1'b1);
        end else begin
            addr_issue_s = addr_reg_r;
        end
    end

    // CSR handshake, address/read-data registers and sticky overrun
    always_ff @(posedge tck) begin
        if (trst) begin
            addr_reg_r  <= '0;
            rdata_r     <= '0;
            overrun_r   <= 1'b0;
            auto_r      <= 1'b0;
            csr_req_r   <= 1'b0;
            csr_we_r    <= 1'b0;
            csr_addr_r  <= '0;
            csr_wdata_r <= '0;
        end else begin
            if (ack_done_s && !csr_we_r) begin
                rdata_r <= csr_rdata;
            end

            // An explicit address write takes precedence over a burst increment.
            if (addr_update_s) begin
                addr_reg_r <= addr_sh_r[ADDR_W-1:0];
            end else if (ack_done_s && auto_r) begin
                addr_reg_r <= addr_reg_r + ADDR_W'(1'b1);
            end

            if (addr_update_s && addr_sh_r[ADDR_W+1]) begin
                overrun_r <= 1'b0;
            end else if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end

            if (issue_s) begin
                csr_req_r   <= 1'b1;
                csr_we_r    <= data_sh_r[DATA_W];
                csr_wdata_r <= data_sh_r[DATA_W-1:0];
                csr_addr_r  <= addr_issue_s;
                auto_r      <= sel_auto_s;
            end else if (ack_done_s) begin
                csr_req_r <= 1'b0;
            end
        end
    end

    // TDO mux: IR chain in SHIR, selected DR chain in SHDR, otherwise quiet
    always_comb begin
        if (sel_idcode_s) begin
            dr_tdo_s = idcode_sh_r[0];
        end else if (sel_addr_s) begin
            dr_tdo_s = addr_sh_r[0];
        end else if (sel_data_s) begin
            dr_tdo_s = data_sh_r[0];
        end else begin
            dr_tdo_s = bypass_sh_r;
        end

        tdo_oe_s = (state_r == SHIR) | (state_r == SHDR);

        if (state_r == SHIR) begin
            tdo_s = ir_sh_r[0];
        end else if (state_r == SHDR) begin
            tdo_s = dr_tdo_s;
        end else begin
            tdo_s = 1'b0;
        end
    end

    assign tdo       = tdo_s;
    assign tdo_oe    = tdo_oe_s;
    assign csr_req   = csr_req_r;
    assign csr_we    = csr_we_r;
    assign csr_addr  = csr_addr_r;
    assign csr_wdata = csr_wdata_r;
    assign dbg_fsm   = state_r;

endmodule

// File: tb/tb_jtag_tap_csr.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_csr
//
// Directed bench for jtag_tap_csr. Expected TDO bits and expected CSR requests
// are queued when the stimulus that causes them is driven, and popped when the
// DUT shifts a bit out or raises csr_req.
// -----------------------------------------------------------------------------
module tb_jtag_tap_csr;

    localparam int unsigned IR_LEN  = 4;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 32;
    localparam logic [31:0] IDCODE  = 32'h1000_0001;
    localparam logic [3:0]  IR_CAP  = 4'b0001;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } req_t;

    logic              tck;
    logic              trst;
    logic              tms;
    logic              tdi;
    logic              tdo;
    logic              tdo_oe;
    logic              csr_req;
    logic              csr_we;
    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_wdata;
    logic              csr_ack;
    logic [DATA_W-1:0] csr_rdata;
    logic [3:0]        dbg_fsm;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   tdo_q[$];
    req_t req_q[$];
    req_t cur_req;
    logic prev_req  = 1'b0;
    int   cur_len   = 0;
    int   last_len  = 0;
    int   ack_mode  = 0;   // 0: never, 1: always, 2: after ack_delay cycles
    int   ack_delay = 0;

    jtag_tap_csr #(
        .IR_LEN     (IR_LEN),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .IDCODE_VAL (IDCODE)
    ) dut (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_oe    (tdo_oe),
        .csr_req   (csr_req),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_ack   (csr_ack),
        .csr_rdata (csr_rdata),
        .dbg_fsm   (dbg_fsm)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the CSR port after an edge and play the CSR slave.
    task automatic observe();
        if (csr_req === 1'b1) begin
            if (prev_req !== 1'b1) begin
                cur_len = 1;
                check("req_queued", (req_q.size() != 0), 1);
                if (req_q.size() != 0) begin
                    cur_req = req_q.pop_front();
                    check("req_we", csr_we, cur_req.we);
                    check("req_addr", csr_addr, cur_req.addr);
                    check("req_wdata", csr_wdata, cur_req.wdata);
                end
            end else begin
                cur_len++;
                check("hold_we", csr_we, cur_req.we);
                check("hold_addr", csr_addr, cur_req.addr);
                check("hold_wdata", csr_wdata, cur_req.wdata);
            end
        end else begin
            if (prev_req === 1'b1) begin
                last_len = cur_len;
            end
            cur_len = 0;
        end
        prev_req  = csr_req;
        csr_ack   = (ack_mode == 1) || (ack_mode == 2 && csr_req === 1'b1 && cur_len > ack_delay);
        csr_rdata = {29'd0, csr_addr} + 32'd100;
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
        observe();
    endtask

    // From RTI: load an instruction, checking the captured IR bits on tdo.
    task automatic load_ir(input logic [3:0] code);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < IR_LEN; i++) begin
            tdo_q.push_back(IR_CAP[i]);
        end
        for (int i = 0; i < IR_LEN; i++) begin
            check("shir_state", dbg_fsm, 4'd11);
            check("ir_tdo", tdo, tdo_q.pop_front());
            step((i == IR_LEN - 1), code[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // DR scan of n bits. The first len bits out are the capture, after that
    // the bits shifted in reappear. from_sel: start in SELDR; to_sel: leave
    // UPDR towards SELDR instead of RTI.
    task automatic shift_dr(input int n, input int len, input logic [63:0] din,
                            input logic [63:0] cap, input bit from_sel, input bit to_sel);
        if (!from_sel) begin
            step(1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tdo_q.push_back((i < len) ? cap[i] : din[i - len]);
        end
        for (int i = 0; i < n; i++) begin
            check("shdr_state", dbg_fsm, 4'd4);
            check("dr_tdo", tdo, tdo_q.pop_front());
            step((i == n - 1), din[i]);
        end
        step(1'b1, 1'b0);
        step(to_sel, 1'b0);
    endtask

    task automatic push_req(input logic we, input logic [2:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic wait_req_low(input int max_cycles);
        for (int i = 0; i < max_cycles && csr_req === 1'b1; i++) begin
            step(1'b0, 1'b0);
        end
        check("req_release", csr_req, 1'b0);
    endtask

    initial begin
        trst      = 1'b1;
        tms       = 1'b1;
        tdi       = 1'b0;
        csr_ack   = 1'b0;
        csr_rdata = 32'd0;

        // Reset and IDCODE
        step(1'b1, 1'b0);
        trst = 1'b0;
        check("rst_fsm", dbg_fsm, 4'd0);
        check("rst_tdo", tdo, 1'b0);
        check("rst_tdo_oe", tdo_oe, 1'b0);
        check("rst_req", csr_req, 1'b0);
        check("rst_we", csr_we, 1'b0);
        check("rst_addr", csr_addr, 3'd0);
        check("rst_wdata", csr_wdata, 32'd0);
        step(1'b0, 1'b0);
        check("rti_tdo_oe", tdo_oe, 1'b0);
        shift_dr(32, 32, 64'd0, {32'd0, IDCODE}, 1'b0, 1'b0);
        check("idcode_req", csr_req, 1'b0);

        // IR capture and BYPASS
        load_ir(4'hF);
        shift_dr(4, 1, 64'b1101, 64'd0, 1'b0, 1'b0);

        // Write with ack three cycles late
        ack_mode  = 2;
        ack_delay = 3;
        load_ir(4'd2);
        shift_dr(5, 5, 64'b00_101, 64'd0, 1'b0, 1'b0);
        load_ir(4'd3);
        push_req(1'b1, 3'd5, 32'hDEAD_BEEF);
        shift_dr(33, 33, {31'd0, 1'b1, 32'hDEAD_BEEF}, 64'd0, 1'b0, 1'b0);
        check("wr_req_first", csr_req, 1'b1);
        wait_req_low(20);
        check("wr_req_len", last_len, 4);

        // Auto-increment reads wrapping 7 -> 0, chained through SELDR
        ack_mode = 1;
        load_ir(4'd2);
        shift_dr(5, 5, 64'b00_110, 64'b00_101, 1'b0, 1'b0);
        load_ir(4'd4);
        push_req(1'b0, 3'd6, 32'd0);
        shift_dr(33, 33, 64'd0, 64'd0, 1'b0, 1'b1);
        push_req(1'b0, 3'd7, 32'd0);
        shift_dr(33, 33, 64'd0, {31'd0, 1'b0, 32'd106}, 1'b1, 1'b1);
        push_req(1'b0, 3'd0, 32'd0);
        shift_dr(33, 33, 64'd0, {31'd0, 1'b0, 32'd107}, 1'b1, 1'b1);
        push_req(1'b0, 3'd1, 32'd0);
        shift_dr(33, 33, 64'd0, {31'd0, 1'b0, 32'd100}, 1'b1, 1'b0);
        wait_req_low(20);
        check("auto_req_len", last_len, 1);

        // Overrun: ack held low, second update dropped
        ack_mode = 0;
        load_ir(4'd2);
        shift_dr(5, 5, 64'b00_011, 64'b00_010, 1'b0, 1'b0);
        load_ir(4'd3);
        push_req(1'b1, 3'd3, 32'h1234_5678);
        shift_dr(33, 33, {31'd0, 1'b1, 32'h1234_5678}, {31'd0, 1'b0, 32'd101}, 1'b0, 1'b0);
        shift_dr(33, 33, {31'd0, 1'b0, 32'hAAAA_5555}, {31'd0, 1'b1, 32'd101}, 1'b0, 1'b0);
        check("ovr_req", csr_req, 1'b1);
        check("ovr_addr", csr_addr, 3'd3);
        check("ovr_wdata", csr_wdata, 32'h1234_5678);
        load_ir(4'd2);
        shift_dr(5, 5, 64'b10_011, 64'b11_011, 1'b0, 1'b0);
        shift_dr(5, 5, 64'b00_011, 64'b01_011, 1'b0, 1'b0);

        // Reset through tms keeps the pending request and the overrun flag
        load_ir(4'd3);
        shift_dr(33, 33, 64'd0, {31'd0, 1'b1, 32'd101}, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
        end
        check("tms_rst_fsm", dbg_fsm, 4'd0);
        check("tms_rst_req", csr_req, 1'b1);
        step(1'b0, 1'b0);
        shift_dr(32, 32, 64'd0, {32'd0, IDCODE}, 1'b0, 1'b0);
        check("tms_rst_req_held", csr_req, 1'b1);
        ack_mode = 1;
        wait_req_low(10);
        load_ir(4'd2);
        shift_dr(5, 5, 64'b00_011, 64'b10_011, 1'b0, 1'b0);

        // trst aborts a pending request and clears overrun
        ack_mode = 0;
        load_ir(4'd3);
        push_req(1'b1, 3'd3, 32'h0F0F_0F0F);
        shift_dr(33, 33, {31'd0, 1'b1, 32'h0F0F_0F0F}, {31'd0, 1'b0, 32'd101}, 1'b0, 1'b0);
        check("trst_req_before", csr_req, 1'b1);
        trst = 1'b1;
        step(1'b0, 1'b0);
        trst = 1'b0;
        check("trst_req", csr_req, 1'b0);
        check("trst_fsm", dbg_fsm, 4'd0);
        check("trst_we", csr_we, 1'b0);
        check("trst_addr", csr_addr, 3'd0);
        check("trst_wdata", csr_wdata, 32'd0);
        check("trst_tdo_oe", tdo_oe, 1'b0);
        step(1'b0, 1'b0);
        load_ir(4'd2);
        shift_dr(5, 5, 64'd0, 64'd0, 1'b0, 1'b0);

        check("req_q_empty", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
